// File: rtl/dsi_link_sequencer.sv
// DSI output path bring-up/shut-down sequencer with per-step timeout supervision.
// Define DSI_LINK_SEQ_AUTO_RETRY_EN to retry LINES_UP from FAULT (up to 3 times).
module dsi_link_sequencer #(
  parameter int unsigned INIT_DELAY_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES    = 4096,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_error,
  input  logic [9:0] pix_fifo_prefill,
  input  logic [9:0] pix_fifo_rdusedw,
  input  logic       lines_ready,
  input  logic       clock_ready,
  input  logic       lines_active,
  input  logic       uploader_active,
  output logic       lines_enable,
  output logic       clock_enable,
  output logic       uploader_enable,
  output logic       streaming_enable,
  output logic [3:0] state,
  output logic       busy,
  output logic       error,
  output logic [1:0] error_code
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
  ,
  output logic [1:0] retry_count
`endif
);

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StLinesUp    = 4'd1,
    StLp11Hold   = 4'd2,
    StClockUp    = 4'd3,
    StPrefill    = 4'd4,
    StStreaming  = 4'd5,
    StStopStream = 4'd6,
    StLinkDown   = 4'd7,
    StFault      = 4'd8
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HoldLast    = CNT_WIDTH'(INIT_DELAY_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lines_en_q, lines_en_d;
  logic                 clock_en_q, clock_en_d;
  logic                 upl_en_q, upl_en_d;
  logic                 strm_en_q, strm_en_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
  logic [1:0]           retry_q, retry_d;
`endif

  logic       timeout, hold_done, abort, fault;
  logic [1:0] fault_code;

  always_comb begin
    state_d    = state_q;
    lines_en_d = lines_en_q;
    clock_en_d = clock_en_q;
    upl_en_d   = upl_en_q;
    strm_en_d  = strm_en_q;
    err_d      = err_q;
    code_d     = code_q;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
    retry_d    = retry_q;
`endif
    abort      = 1'b0;
    fault      = 1'b0;
    fault_code = 2'd0;
    timeout    = (cnt_q == TimeoutLast);
    hold_done  = (cnt_q == HoldLast);

    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d    = StLinesUp;
          lines_en_d = 1'b1;
        end
      end
      StLinesUp: begin
        if (stop) abort = 1'b1;
        else if (lines_ready) state_d = StLp11Hold;
        else if (timeout) begin
          fault      = 1'b1;
          fault_code = 2'd1;
        end
      end
      StLp11Hold: begin
        if (stop) abort = 1'b1;
        else if (hold_done) begin
          state_d    = StClockUp;
          clock_en_d = 1'b1;
        end
      end
      StClockUp: begin
        if (stop) abort = 1'b1;
        else if (clock_ready) begin
          state_d  = StPrefill;
          upl_en_d = 1'b1;
        end else if (timeout) begin
          fault      = 1'b1;
          fault_code = 2'd2;
        end
      end
      StPrefill: begin
        if (stop) abort = 1'b1;
        else if (pix_fifo_rdusedw >= pix_fifo_prefill) begin
          state_d   = StStreaming;
          strm_en_d = 1'b1;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
          // Reaching STREAMING proves the link works: forget earlier faults.
          err_d     = 1'b0;
          code_d    = 2'd0;
          retry_d   = 2'd0;
`endif
        end else if (timeout) begin
          fault      = 1'b1;
          fault_code = 2'd3;
        end
      end
      StStreaming: begin
        if (stop) abort = 1'b1;
      end
      StStopStream: begin
        if (!lines_active && !uploader_active) begin
          state_d    = StLinkDown;
          clock_en_d = 1'b0;
        end else if (timeout) begin
          fault      = 1'b1;
          fault_code = 2'd3;
        end
      end
      StLinkDown: begin
        if (!clock_ready) begin
          state_d    = StIdle;
          lines_en_d = 1'b0;
        end else if (timeout) begin
          fault      = 1'b1;
          fault_code = 2'd2;
        end
      end
      StFault: begin
        if (clear_error) begin
          state_d = StIdle;
          err_d   = 1'b0;
          code_d  = 2'd0;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
          retry_d = 2'd0;
        end else if (retry_q != 2'd3 && hold_done) begin
          state_d    = StLinesUp;
          lines_en_d = 1'b1;
          retry_d    = retry_q + 2'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StStopStream;
      upl_en_d  = 1'b0;
      strm_en_d = 1'b0;
    end else if (fault) begin
      state_d    = StFault;
      lines_en_d = 1'b0;
      clock_en_d = 1'b0;
      upl_en_d   = 1'b0;
      strm_en_d  = 1'b0;
      err_d      = 1'b1;
      // Only the first fault code survives until acknowledged.
      code_d     = err_q ? code_q : fault_code;
    end

    cnt_d  = (state_d != state_q) ? '0 :
             (timeout ? cnt_q : cnt_q + CNT_WIDTH'(1));
    busy_d = (state_d != StIdle) && (state_d != StFault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lines_en_q <= 1'b0;
      clock_en_q <= 1'b0;
      upl_en_q   <= 1'b0;
      strm_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lines_en_q <= lines_en_d;
      clock_en_q <= clock_en_d;
      upl_en_q   <= upl_en_d;
      strm_en_q  <= strm_en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      code_q     <= code_d;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign lines_enable     = lines_en_q;
  assign clock_enable     = clock_en_q;
  assign uploader_enable  = upl_en_q;
  assign streaming_enable = strm_en_q;
  assign state            = state_q;
  assign busy             = busy_q;
  assign error            = err_q;
  assign error_code       = code_q;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
  assign retry_count      = retry_q;
`endif

endmodule

// File: tb/tb_dsi_link_sequencer.sv
// Directed bench for dsi_link_sequencer: phase-table reference model checked every cycle,
// plus hand-timed literal checkpoints for each scenario.
module tb_dsi_link_sequencer;

  localparam int ID = 8;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear_error = 1'b0;
  logic [9:0] pix_fifo_prefill = 10'd16;
  logic [9:0] pix_fifo_rdusedw = 10'd0;
  logic       lines_ready = 1'b0, clock_ready = 1'b0;
  logic       lines_active = 1'b0, uploader_active = 1'b0;
  logic       lines_enable, clock_enable, uploader_enable, streaming_enable;
  logic [3:0] state;
  logic       busy, error;
  logic [1:0] error_code;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
  logic [1:0] retry_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dsi_link_sequencer #(
    .INIT_DELAY_CYCLES(ID),
    .TIMEOUT_CYCLES   (TO),
    .CNT_WIDTH        (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .clear_error     (clear_error),
    .pix_fifo_prefill(pix_fifo_prefill),
    .pix_fifo_rdusedw(pix_fifo_rdusedw),
    .lines_ready     (lines_ready),
    .clock_ready     (clock_ready),
    .lines_active    (lines_active),
    .uploader_active (uploader_active),
    .lines_enable    (lines_enable),
    .clock_enable    (clock_enable),
    .uploader_enable (uploader_enable),
    .streaming_enable(streaming_enable),
    .state           (state),
    .busy            (busy),
    .error           (error),
    .error_code      (error_code)
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
    ,
    .retry_count     (retry_count)
`endif
  );

  // Reference model: phase number, cycles spent in it, and fault bookkeeping.
  int m_phase, m_since, m_code, m_retry;
  bit m_err, m_ce_in_stop;
  int nx;

  function automatic bit exit_ok(input int ph);
    case (ph)
      1: return lines_ready;
      2: return m_since == ID - 1;
      3: return clock_ready;
      4: return pix_fifo_rdusedw >= pix_fifo_prefill;
      6: return !lines_active && !uploader_active;
      7: return !clock_ready;
      default: return 1'b0;
    endcase
  endfunction

  // Fault code raised when a supervised phase times out; 0 means unsupervised.
  function automatic int code_of(input int ph);
    case (ph)
      1: return 1;
      3: return 2;
      4: return 3;
      6: return 3;
      7: return 2;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_since <= 0; m_code <= 0; m_retry <= 0;
      m_err <= 1'b0; m_ce_in_stop <= 1'b0;
    end else begin
      nx = m_phase;
      if (m_phase == 0) begin
        if (start && !stop) nx = 1;
      end else if (m_phase == 8) begin
        if (clear_error) nx = 0;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
        else if (m_retry < 3 && m_since == ID - 1) nx = 1;
`endif
      end else if (stop && m_phase <= 5) nx = 6;
      else if (exit_ok(m_phase)) nx = (m_phase == 7) ? 0 : m_phase + 1;
      else if (code_of(m_phase) != 0 && m_since >= TO - 1) nx = 8;

      if (nx == 8 && m_phase != 8) begin
        m_err <= 1'b1;
        if (!m_err) m_code <= code_of(m_phase);
      end
      if (m_phase == 8 && nx == 0) begin
        m_err <= 1'b0; m_code <= 0; m_retry <= 0;
      end
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
      if (m_phase == 8 && nx == 1) m_retry <= m_retry + 1;
      if (nx == 5 && m_phase != 5) begin
        m_err <= 1'b0; m_code <= 0; m_retry <= 0;
      end
`endif
      if (nx == 6 && m_phase != 6) m_ce_in_stop <= (m_phase >= 3);
      m_since <= (nx != m_phase) ? 0 : m_since + 1;
      m_phase <= nx;
    end
  end

  logic [11:0] exp_vec, got_vec;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_vec = {4'(m_phase),
                 1'(m_phase >= 1 && m_phase <= 7),
                 1'((m_phase >= 3 && m_phase <= 5) || (m_phase == 6 && m_ce_in_stop)),
                 1'(m_phase == 4 || m_phase == 5),
                 1'(m_phase == 5),
                 1'(m_phase >= 1 && m_phase <= 7),
                 m_err, 2'(m_code)};
      got_vec = {state, lines_enable, clock_enable, uploader_enable, streaming_enable,
                 busy, error, error_code};
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, got_vec, exp_vec);
      end
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
      total++;
      if (retry_count !== 2'(m_retry)) begin
        bad++;
        $display("FAIL model_retry t=%0t got=%0d expected=%0d", $time, retry_count, m_retry);
      end
`endif
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; clear_error = 1'b0;
    pix_fifo_prefill = 10'd16; pix_fifo_rdusedw = 10'd0;
    lines_ready = 1'b0; clock_ready = 1'b0; lines_active = 1'b0; uploader_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bring-up then shutdown; outputs checked at cycle c reflect edges up to c.
    do_reset();
    for (int c = 0; c <= 53; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("reset_state", state, 0); chk("reset_busy", busy, 0);
        chk("reset_lines_en", lines_enable, 0); chk("reset_error", error, 0);
      end
      if (c == 1) begin chk("up_state1", state, 1); chk("up_lines_en", lines_enable, 1); end
      if (c == 6) chk("up_lp11", state, 2);
      if (c == 13) chk("up_clk_en_early", clock_enable, 0);
      if (c == 14) begin chk("up_clk_en", clock_enable, 1); chk("up_state3", state, 3); end
      if (c == 18) begin chk("up_upl_en", uploader_enable, 1); chk("up_state4", state, 4); end
      if (c == 34) chk("up_strm_early", streaming_enable, 0);
      if (c == 35) begin
        chk("up_strm_en", streaming_enable, 1); chk("up_state5", state, 5); chk("up_busy", busy, 1);
      end
      if (c == 38) begin
        chk("dn_state6", state, 6); chk("dn_strm_off", streaming_enable, 0);
        chk("dn_upl_off", uploader_enable, 0); chk("dn_clk_held", clock_enable, 1);
      end
      if (c == 47) chk("dn_clk_still", clock_enable, 1);
      if (c == 48) begin chk("dn_state7", state, 7); chk("dn_clk_off", clock_enable, 0); end
      if (c == 52) chk("dn_lines_held", lines_enable, 1);
      if (c == 53) begin
        chk("dn_idle", state, 0); chk("dn_lines_off", lines_enable, 0); chk("dn_busy", busy, 0);
      end
      start = (c == 0);
      stop = (c == 37);
      if (c == 5) lines_ready = 1'b1;
      if (c == 17) clock_ready = 1'b1;
      if (c == 52) clock_ready = 1'b0;
      if (c >= 18) pix_fifo_rdusedw = 10'((c - 18) > 31 ? 31 : (c - 18));
      if (c == 35) lines_active = 1'b1;
      if (c == 47) lines_active = 1'b0;
    end

    // lines_ready never arrives: timeout fault, start ignored, clear_error recovers.
    do_reset();
    for (int c = 0; c <= 37; c++) begin
      @(negedge clk);
      if (c == 32) chk("to_still_lu", state, 1);
      if (c == 33) begin
        chk("to_fault", state, 8); chk("to_error", error, 1); chk("to_code", error_code, 1);
        chk("to_lines_off", lines_enable, 0); chk("to_busy", busy, 0);
      end
      if (c == 35) begin chk("to_start_ign", state, 8); chk("to_start_le", lines_enable, 0); end
      if (c == 37) begin
        chk("to_clr_state", state, 0); chk("to_clr_err", error, 0); chk("to_clr_code", error_code, 0);
      end
      start = (c == 0 || c == 34);
      clear_error = (c == 36);
    end

    // Abort while holding LP-11.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) chk("ab_lp11", state, 2);
      if (c == 6) begin chk("ab_stop_st", state, 6); chk("ab_clk_never", clock_enable, 0); end
      if (c == 7) begin chk("ab_link_dn", state, 7); chk("ab_clk_never2", clock_enable, 0); end
      if (c == 8) begin chk("ab_idle", state, 0); chk("ab_lines_off", lines_enable, 0); end
      start = (c == 0);
      stop = (c == 5);
      lines_ready = 1'b1;
    end

    // Simultaneous start and stop in IDLE.
    do_reset();
    for (int c = 0; c <= 1; c++) begin
      @(negedge clk);
      if (c == 1) begin chk("ss_idle", state, 0); chk("ss_lines", lines_enable, 0); end
      start = (c == 0);
      stop = (c == 0);
    end
    start = 1'b0; stop = 1'b0;

    // Zero prefill, then asynchronous reset while streaming.
    do_reset();
    pix_fifo_prefill = 10'd0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c == 10) chk("pz_clock_up", state, 3);
      if (c == 11) chk("pz_prefill", state, 4);
      if (c == 12) begin chk("pz_stream", state, 5); chk("pz_strm_en", streaming_enable, 1); end
      start = (c == 0);
      lines_ready = 1'b1;
      clock_ready = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_enables", {lines_enable, clock_enable, uploader_enable, streaming_enable}, 0);
    chk("ar_busy_err", {busy, error, error_code}, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
    // clock_ready stuck low: three retries, then FAULT holds until cleared.
    do_reset();
    for (int c = 0; c <= 231; c++) begin
      @(negedge clk);
      if (c == 42) begin
        chk("rt_fault1", state, 8); chk("rt_code", error_code, 2); chk("rt_cnt0", retry_count, 0);
      end
      if (c == 50) begin
        chk("rt_retry1", state, 1); chk("rt_cnt1", retry_count, 1); chk("rt_err_kept", error, 1);
      end
      if (c == 99) begin chk("rt_retry2", state, 1); chk("rt_cnt2", retry_count, 2); end
      if (c == 148) begin chk("rt_retry3", state, 1); chk("rt_cnt3", retry_count, 3); end
      if (c == 189) chk("rt_fault4", state, 8);
      if (c == 230) begin
        chk("rt_stuck", state, 8); chk("rt_stuck_code", error_code, 2);
        chk("rt_stuck_cnt", retry_count, 3);
      end
      if (c == 231) begin
        chk("rt_clr_state", state, 0); chk("rt_clr_cnt", retry_count, 0); chk("rt_clr_err", error, 0);
      end
      start = (c == 0);
      clear_error = (c == 230);
      lines_ready = 1'b1;
    end
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsi_link_sequencer.md
Name: dsi_link_sequencer

Overview:
Sequences bring-up and shut-down of the DSI output path in the clk_sys domain. It drives lines_enable and clock_enable of dsi_lanes_controller, enable of pixel_uploader, and streaming_enable of packets_assembler, gating each step on the downstream ready/active status. It supervises every wait step with a timeout and latches a fault code, so software only issues start/stop/clear pulses.

Parameters:
INIT_DELAY_CYCLES, 1000, LP-11 hold time (cycles) after lines_ready before clock_enable; legal range 1..TIMEOUT_CYCLES
TIMEOUT_CYCLES, 4096, max cycles spent waiting in any supervised state
CNT_WIDTH, 16, width of internal step counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  system clock (clk_sys domain)
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to bring the link up
stop  input  1  single-cycle request to bring the link down
clear_error  input  1  single-cycle fault acknowledge
pix_fifo_prefill  input  10  pixel FIFO fill level required before streaming starts
pix_fifo_rdusedw  input  10  pixel FIFO read-side used words, clk domain
lines_ready  input  1  from lanes controller
clock_ready  input  1  from lanes controller
lines_active  input  1  from lanes controller
uploader_active  input  1  pixel_uploader active
lines_enable  output  1  to lanes controller
clock_enable  output  1  to lanes controller
uploader_enable  output  1  to pixel_uploader enable
streaming_enable  output  1  to packets_assembler
state  output  4  current state encoding
busy  output  1  state != IDLE and state != FAULT
error  output  1  fault latched
error_code  output  2  0 none, 1 lines_ready timeout, 2 clock_ready timeout (up or down), 3 prefill/drain timeout

Behaviour:
- Reset: all outputs 0, state IDLE(0). All outputs are registered and change on the clock edge after the condition is sampled.
- State encodings: IDLE=0, LINES_UP=1, LP11_HOLD=2, CLOCK_UP=3, PREFILL=4, STREAMING=5, STOP_STREAM=6, LINK_DOWN=7, FAULT=8.
- Step counter: cleared on every state entry, increments each cycle, saturates. "timeout" means counter == TIMEOUT_CYCLES-1 while the exit condition is still false. If both occur in the same cycle, the exit condition wins.
- IDLE: start && !stop -> LINES_UP, lines_enable=1. If start and stop arrive together, stop wins and the block stays in IDLE.
- LINES_UP: lines_ready -> LP11_HOLD. timeout -> FAULT, code 1.
- LP11_HOLD: counter == INIT_DELAY_CYCLES-1 -> CLOCK_UP, clock_enable=1.
- CLOCK_UP: clock_ready -> PREFILL, uploader_enable=1. timeout -> FAULT, code 2.
- PREFILL: pix_fifo_rdusedw >= pix_fifo_prefill (unsigned) -> STREAMING, streaming_enable=1. timeout -> FAULT, code 3. A prefill value of 0 passes on the first cycle.
- STREAMING: stays until stop.
- stop in any state LINES_UP..STREAMING -> STOP_STREAM; streaming_enable=0 and uploader_enable=0 on the next edge. Enables that were never raised stay 0.
- STOP_STREAM: !lines_active && !uploader_active -> LINK_DOWN, clock_enable=0. timeout -> FAULT, code 3.
- LINK_DOWN: !clock_ready -> IDLE, lines_enable=0. timeout -> FAULT, code 2.
- FAULT: all four enables 0 on entry, error=1, error_code latched (first fault only). start and stop are ignored. clear_error -> IDLE, error=0, error_code=0.
- start in any non-IDLE state and clear_error outside FAULT: ignored.
- Reset mid-operation: immediate asynchronous return to the reset state, with no shutdown sequence.

Optional Feature:
DSI_LINK_SEQ_AUTO_RETRY_EN.
- Defined:
  - FAULT holds for INIT_DELAY_CYCLES, then re-enters LINES_UP with lines_enable=1, keeping error=1 and error_code.
  - A 2-bit retry counter allows at most 3 retries; after that the block stays in FAULT until clear_error.
  - A successful entry to STREAMING clears the retry counter, error and error_code.
  - Adds output port retry_count [1:0], reset 0.
- Undefined: FAULT is held until clear_error, and retry_count does not exist.

Test Plan:
Bench parameters for all scenarios: INIT_DELAY_CYCLES=8, TIMEOUT_CYCLES=32, pix_fifo_prefill=16.
1. Bring-up: start at cycle 0; lines_ready at cycle 5; clock_ready 3 cycles after clock_enable; rdusedw ramps by 1 per cycle -> lines_enable=1 at cycle 1; clock_enable rises exactly 8 cycles after LP11_HOLD entry; uploader_enable 1 cycle after clock_ready; streaming_enable 1 cycle after rdusedw=16; state=5; busy=1.
2. Shutdown: stop in STREAMING; lines_active held 10 more cycles -> streaming_enable and uploader_enable 0 next cycle; clock_enable 0 one cycle after lines_active falls; clock_ready dropped 4 cycles later -> lines_enable 0 next cycle; state=0; busy=0.
3. Timeout: lines_ready tied 0 -> FAULT at cycle 33 with error=1, error_code=1, all enables 0; start pulse has no effect; clear_error -> state=0, error=0.
4. Abort during LP11_HOLD (stop at counter=3) -> clock_enable never rises, passes STOP_STREAM and LINK_DOWN, ends in IDLE with lines_enable=0.
5. Edge cases:
   - start and stop in the same IDLE cycle -> stays IDLE.
   - rst_n low mid-STREAMING -> all outputs 0 without waiting for a clock edge.
   - prefill=0 -> STREAMING one cycle after PREFILL entry.
6. With DSI_LINK_SEQ_AUTO_RETRY_EN and clock_ready stuck 0 -> 3 retries (retry_count 1,2,3), then stays in FAULT with error_code=2; clear_error -> IDLE, retry_count=0.
